// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencing stage.
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        TAKE    = 2'b01,
        HANDLER = 2'b10,
        RETURN  = 2'b11
    } exc_state_t;

    // PC redirect selects driven to the fetch stage
    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_VEC = 2'b01;
    localparam logic [1:0] PCSEL_ELR = 2'b10;

    // Cause codes carried on EStatus
    localparam logic [3:0] ESTAT_BADOP = 4'b0001;
    localparam logic [3:0] ESTAT_IRQ   = 4'b0010;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for the asynchronous device interrupt level.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_raw,
    output logic irq_sync_out
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw level through the flop chain; oldest sample exits at the top
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], irq_raw};
        end
    end

    assign irq_sync_out = sync_r[STAGES-1];

endmodule

// File: rtl/exc_unit.sv
// Exception/interrupt sequencer: IRQ synchronisation, ELR/ESR capture,
// exception entry/return PC redirect and pipeline flush.
module exc_unit
    import exc_pkg::*;
#(
    parameter int           N           = 64,
    parameter logic [N-1:0] EXC_VECTOR  = 64'hD8,
    parameter int           SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         IRQ_raw,
    output logic         ExtIRQ,
    input  logic         Exc,
    input  logic         ERet,
    input  logic [3:0]   EStatus,
    input  logic [N-1:0] PC_exc,
    output logic         ExcAck,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic [N-1:0] ExcVector,
    output logic [1:0]   PCSel,
    output logic         Flush,
    output logic         InHandler
);

    exc_state_t state_r;
    logic       irq_sync_s;
    logic       irq_unmask_r;  // high while state_r is IDLE or TAKE
    logic       excack_r;
    logic       flush_r;
    logic       inhandler_r;
    logic [1:0] pcsel_r;
    logic [N-1:0] elr_r;
    logic [3:0]   esr_r;

    irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk          (clk),
        .reset        (reset),
        .irq_raw      (IRQ_raw),
        .irq_sync_out (irq_sync_s)
    );

    // Sequencer FSM; outputs are registered alongside the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            irq_unmask_r <= 1'b1;
            excack_r     <= 1'b0;
            flush_r      <= 1'b0;
            inhandler_r  <= 1'b0;
            pcsel_r      <= PCSEL_SEQ;
            elr_r        <= '0;
            esr_r        <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    // Exc takes priority over a simultaneous ERet, which is meaningless here
                    if (Exc) begin
                        state_r      <= TAKE;
                        elr_r        <= PC_exc;
                        esr_r        <= EStatus;
                        irq_unmask_r <= 1'b1;
                        excack_r     <= 1'b1;
                        flush_r      <= 1'b1;
                        inhandler_r  <= 1'b0;
                        pcsel_r      <= PCSEL_VEC;
                    end else begin
                        state_r      <= IDLE;
                        irq_unmask_r <= 1'b1;
                        excack_r     <= 1'b0;
                        flush_r      <= 1'b0;
                        inhandler_r  <= 1'b0;
                        pcsel_r      <= PCSEL_SEQ;
                    end
                end
                TAKE: begin
                    state_r      <= HANDLER;
                    irq_unmask_r <= 1'b0;
                    excack_r     <= 1'b0;
                    flush_r      <= 1'b0;
                    inhandler_r  <= 1'b1;
                    pcsel_r      <= PCSEL_SEQ;
                end
                HANDLER: begin
                    // Nested Exc is dropped; ELR/ESR keep the original context
                    if (ERet) begin
                        state_r      <= RETURN;
                        irq_unmask_r <= 1'b0;
                        excack_r     <= 1'b0;
                        flush_r      <= 1'b1;
                        inhandler_r  <= 1'b1;
                        pcsel_r      <= PCSEL_ELR;
                    end else begin
                        state_r      <= HANDLER;
                        irq_unmask_r <= 1'b0;
                        excack_r     <= 1'b0;
                        flush_r      <= 1'b0;
                        inhandler_r  <= 1'b1;
                        pcsel_r      <= PCSEL_SEQ;
                    end
                end
                RETURN: begin
                    state_r      <= IDLE;
                    irq_unmask_r <= 1'b1;
                    excack_r     <= 1'b0;
                    flush_r      <= 1'b0;
                    inhandler_r  <= 1'b0;
                    pcsel_r      <= PCSEL_SEQ;
                end
                default: begin
                    state_r      <= IDLE;
                    irq_unmask_r <= 1'b1;
                    excack_r     <= 1'b0;
                    flush_r      <= 1'b0;
                    inhandler_r  <= 1'b0;
                    pcsel_r      <= PCSEL_SEQ;
                end
            endcase
        end
    end

    // IRQ stays visible in TAKE so the controller can acknowledge the device
    assign ExtIRQ    = irq_sync_s & irq_unmask_r;
    assign ExcAck    = excack_r;
    assign Flush     = flush_r;
    assign InHandler = inhandler_r;
    assign PCSel     = pcsel_r;
    assign ELR       = elr_r;
    assign ESR       = esr_r;
    assign ExcVector = EXC_VECTOR;

endmodule

// File: tb/tb_exc_unit.sv
// Self-checking bench for exc_unit: cycle model plus directed literal checks.
module tb_exc_unit;
    import exc_pkg::*;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         IRQ_raw;
    logic         ExtIRQ;
    logic         Exc;
    logic         ERet;
    logic [3:0]   EStatus;
    logic [N-1:0] PC_exc;
    logic         ExcAck;
    logic [N-1:0] ELR;
    logic [3:0]   ESR;
    logic [N-1:0] ExcVector;
    logic [1:0]   PCSel;
    logic         Flush;
    logic         InHandler;

    int checks = 0;
    int errors = 0;

    exc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .IRQ_raw   (IRQ_raw),
        .ExtIRQ    (ExtIRQ),
        .Exc       (Exc),
        .ERet      (ERet),
        .EStatus   (EStatus),
        .PC_exc    (PC_exc),
        .ExcAck    (ExcAck),
        .ELR       (ELR),
        .ESR       (ESR),
        .ExcVector (ExcVector),
        .PCSel     (PCSel),
        .Flush     (Flush),
        .InHandler (InHandler)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode flags: "ack_cycle" = the one cycle after an accepted exception,
    // "in_handler" = handler running, "ret_cycle" = the one cycle after ERET.
    bit          m_ack_cycle, m_in_handler, m_ret_cycle;
    bit          irq_hist [2];
    logic [63:0] m_elr;
    logic [3:0]  m_esr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ack_cycle  = 1'b0;
            m_in_handler = 1'b0;
            m_ret_cycle  = 1'b0;
            irq_hist[0]  = 1'b0;
            irq_hist[1]  = 1'b0;
            m_elr        = 64'h0;
            m_esr        = 4'h0;
        end else begin
            irq_hist[1] = irq_hist[0];
            irq_hist[0] = IRQ_raw;
            if (m_ack_cycle) begin
                m_ack_cycle  = 1'b0;
                m_in_handler = 1'b1;
            end else if (m_ret_cycle) begin
                m_ret_cycle = 1'b0;
            end else if (m_in_handler) begin
                if (ERet) begin
                    m_in_handler = 1'b0;
                    m_ret_cycle  = 1'b1;
                end
            end else if (Exc) begin
                m_ack_cycle = 1'b1;
                m_elr       = PC_exc;
                m_esr       = EStatus;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(posedge clk) begin
        #2;
        check("ExcAck",    {63'b0, ExcAck},    {63'b0, m_ack_cycle});
        check("Flush",     {63'b0, Flush},     {63'b0, (m_ack_cycle | m_ret_cycle)});
        check("InHandler", {63'b0, InHandler}, {63'b0, (m_in_handler | m_ret_cycle)});
        check("PCSel",     {62'b0, PCSel},
              m_ack_cycle ? 64'd1 : (m_ret_cycle ? 64'd2 : 64'd0));
        check("ExtIRQ",    {63'b0, ExtIRQ},
              {63'b0, (irq_hist[1] & ~(m_in_handler | m_ret_cycle))});
        check("ELR",       ELR,                m_elr);
        check("ESR",       {60'b0, ESR},       {60'b0, m_esr});
        check("ExcVector", ExcVector,          64'hD8);
    end

    // Watchdog so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic go_idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0; IRQ_raw = 1'b1; Exc = 1'b0; ERet = 1'b0;
        EStatus = 4'h0; PC_exc = 64'h0;

        // 1: reset with IRQ high, then release and time ExtIRQ
        go_idle_cycles(3);
        check("rst_ExtIRQ", {63'b0, ExtIRQ}, 64'd0);
        check("rst_ELR", ELR, 64'd0);
        check("rst_PCSel", {62'b0, PCSel}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("sync_edge1", {63'b0, ExtIRQ}, 64'd0);
        @(posedge clk); #1;
        check("sync_edge2", {63'b0, ExtIRQ}, 64'd1);
        @(negedge clk);
        IRQ_raw = 1'b0;
        go_idle_cycles(3);

        // 2: bad-opcode exception from IDLE
        Exc = 1'b1; EStatus = ESTAT_BADOP; PC_exc = 64'h40;
        @(posedge clk); #1;
        check("take_ack", {63'b0, ExcAck}, 64'd1);
        check("take_pcsel", {62'b0, PCSel}, 64'd1);
        check("take_flush", {63'b0, Flush}, 64'd1);
        check("take_elr", ELR, 64'h40);
        check("take_esr", {60'b0, ESR}, 64'd1);
        check("take_inh", {63'b0, InHandler}, 64'd0);
        @(negedge clk);
        Exc = 1'b0;
        @(posedge clk); #1;
        check("hdl_inh", {63'b0, InHandler}, 64'd1);

        // 3: nested Exc ignored, then ERET
        @(negedge clk);
        Exc = 1'b1; PC_exc = 64'h80; EStatus = ESTAT_IRQ;
        @(posedge clk); #1;
        check("nest_ack", {63'b0, ExcAck}, 64'd0);
        @(negedge clk);
        Exc = 1'b0;
        @(posedge clk); #1;
        check("nest_elr", ELR, 64'h40);
        check("nest_esr", {60'b0, ESR}, 64'd1);
        @(negedge clk);
        ERet = 1'b1;
        @(posedge clk); #1;
        check("ret_pcsel", {62'b0, PCSel}, 64'd2);
        check("ret_flush", {63'b0, Flush}, 64'd1);
        @(negedge clk);
        ERet = 1'b0;
        @(posedge clk); #1;
        check("idle_pcsel", {62'b0, PCSel}, 64'd0);
        check("idle_inh", {63'b0, InHandler}, 64'd0);

        // 4: IRQ-caused exception, masking in handler, pending IRQ on return
        @(negedge clk);
        IRQ_raw = 1'b1;
        go_idle_cycles(3);
        Exc = 1'b1; EStatus = ESTAT_IRQ; PC_exc = 64'h100;
        @(posedge clk); #1;
        check("irq_iack", {63'b0, (ExcAck & ExtIRQ)}, 64'd1);
        @(negedge clk);
        Exc = 1'b0;
        @(posedge clk); #1;
        check("irq_masked", {63'b0, ExtIRQ}, 64'd0);
        go_idle_cycles(2);
        ERet = 1'b1;
        @(posedge clk); #1;
        check("irq_masked_ret", {63'b0, ExtIRQ}, 64'd0);
        @(negedge clk);
        ERet = 1'b0;
        @(posedge clk); #1;
        check("irq_pending", {63'b0, ExtIRQ}, 64'd1);
        @(negedge clk);
        IRQ_raw = 1'b0;
        go_idle_cycles(3);

        // 5: Exc and ERet together in IDLE; then ERet alone in IDLE
        Exc = 1'b1; ERet = 1'b1; EStatus = ESTAT_BADOP; PC_exc = 64'h200;
        @(posedge clk); #1;
        check("both_ack", {63'b0, ExcAck}, 64'd1);
        check("both_elr", ELR, 64'h200);
        @(negedge clk);
        Exc = 1'b0; ERet = 1'b0;
        go_idle_cycles(1);
        ERet = 1'b1;
        go_idle_cycles(2);
        ERet = 1'b0;
        go_idle_cycles(1);
        ERet = 1'b1;
        @(posedge clk); #1;
        check("eret_idle_pcsel", {62'b0, PCSel}, 64'd0);
        check("eret_idle_flush", {63'b0, Flush}, 64'd0);
        @(negedge clk);
        ERet = 1'b0;
        go_idle_cycles(1);

        // 6a: asynchronous reset during TAKE
        Exc = 1'b1; EStatus = ESTAT_IRQ; PC_exc = 64'h300;
        @(posedge clk); #3;
        Exc = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_take_ack", {63'b0, ExcAck}, 64'd0);
        check("rst_take_flush", {63'b0, Flush}, 64'd0);
        check("rst_take_elr", ELR, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        go_idle_cycles(1);

        // 6b: asynchronous reset during HANDLER
        Exc = 1'b1; EStatus = ESTAT_BADOP; PC_exc = 64'h400;
        @(negedge clk);
        Exc = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("rst_hdl_inh", {63'b0, InHandler}, 64'd0);
        check("rst_hdl_esr", {60'b0, ESR}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_pcsel", {62'b0, PCSel}, 64'd0);
        check("post_rst_elr", ELR, 64'd0);
        go_idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
